// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory ready handshake.
// Optional memory-wait timeout enabled by defining MC_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  Op_i,
  input  logic        Zero_i,
  input  logic        mem_ready_i,
  output logic        IorD_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        IRWrite_o,
  output logic        RegDst_o,
  output logic        MemtoReg_o,
  output logic        RegWrite_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ALUOp_o,
  output logic [1:0]  PCSrc_o,
  output logic        PCWrite_o,
  output logic        Illegal_o,
  output logic        Timeout_o,
  output logic [3:0]  State_o,
  output logic [31:0] Retired_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StAluWb  = 4'd7,
    StExecI  = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e      state_q, state_d, state_raw;
  logic [31:0] retired_q;
  logic        retire, mem_wait, abort;
  logic        mem_read, mem_write, ir_write, reg_write, pc_write;

  always_comb begin
    state_raw  = state_q;
    retire     = 1'b0;
    mem_wait   = 1'b0;
    IorD_o     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    reg_write  = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    ALUOp_o    = 2'b00;
    PCSrc_o    = 2'b00;
    pc_write   = 1'b0;
    Illegal_o  = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        ALUSrcB_o = 2'b01;
        ALUOp_o   = 2'b01;
        ir_write  = mem_ready_i;
        pc_write  = mem_ready_i;
        if (mem_ready_i) state_raw = StDecode;
        else             mem_wait  = 1'b1;
      end
      StDecode: begin
        ALUSrcB_o = 2'b11;
        ALUOp_o   = 2'b01;
        case (Op_i)
          OpLw, OpSw:     state_raw = StMemAdr;
          OpRtype:        state_raw = StExecR;
          OpAddi, OpOri:  state_raw = StExecI;
          OpBeq:          state_raw = StBranch;
          OpJ:            state_raw = StJump;
          default: begin
            state_raw = StFetch;
            Illegal_o = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = 2'b01;
        state_raw = (Op_i == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        IorD_o   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready_i) state_raw = StMemWb;
        else             mem_wait  = 1'b1;
      end
      StMemWb: begin
        MemtoReg_o = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_raw  = StFetch;
      end
      StMemWr: begin
        IorD_o    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready_i) begin
          retire    = 1'b1;
          state_raw = StFetch;
        end else begin
          mem_wait  = 1'b1;
        end
      end
      StExecR: begin
        ALUSrcA_o = 1'b1;
        state_raw = StAluWb;
      end
      StAluWb: begin
        RegDst_o  = (Op_i == OpRtype);
        reg_write = 1'b1;
        retire    = 1'b1;
        state_raw = StFetch;
      end
      StExecI: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
        ALUOp_o   = (Op_i == OpOri) ? 2'b10 : 2'b01;
        state_raw = StAluWb;
      end
      StBranch: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b11;
        PCSrc_o   = 2'b01;
        pc_write  = Zero_i;
        retire    = 1'b1;
        state_raw = StFetch;
      end
      StJump: begin
        PCSrc_o   = 2'b10;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_raw = StFetch;
      end
      default: state_raw = StFetch;
    endcase
  end

  assign state_d = abort ? StFetch : state_raw;

  // Reset must suppress every write/request even before the state register is known.
  assign MemRead_o  = mem_read  & ~rst_i;
  assign MemWrite_o = mem_write & ~rst_i;
  assign IRWrite_o  = ir_write  & ~rst_i;
  assign RegWrite_o = reg_write & ~rst_i;
  assign PCWrite_o  = pc_write  & ~rst_i;
  assign State_o    = state_q;
  assign Retired_o  = retired_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

`ifdef MC_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    abort     = mem_wait && (wait_q == WaitW'(WAIT_MAX));
    wait_d    = (mem_wait && !abort) ? wait_q + 1'b1 : '0;
    timeout_d = timeout_q | abort;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{WAIT_MAX, mem_wait};
  assign abort      = 1'b0;
  assign Timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; covers MC_TIMEOUT_EN when defined.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [5:0]  Op_i;
  logic        Zero_i;
  logic        mem_ready_i;
  logic        IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o;
  logic        RegWrite_o, ALUSrcA_o, PCWrite_o, Illegal_o, Timeout_o;
  logic [1:0]  ALUSrcB_o, ALUOp_o, PCSrc_o;
  logic [3:0]  State_o;
  logic [31:0] Retired_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(.WAIT_MAX(15)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .Op_i        (Op_i),
    .Zero_i      (Zero_i),
    .mem_ready_i (mem_ready_i),
    .IorD_o      (IorD_o),
    .MemRead_o   (MemRead_o),
    .MemWrite_o  (MemWrite_o),
    .IRWrite_o   (IRWrite_o),
    .RegDst_o    (RegDst_o),
    .MemtoReg_o  (MemtoReg_o),
    .RegWrite_o  (RegWrite_o),
    .ALUSrcA_o   (ALUSrcA_o),
    .ALUSrcB_o   (ALUSrcB_o),
    .ALUOp_o     (ALUOp_o),
    .PCSrc_o     (PCSrc_o),
    .PCWrite_o   (PCWrite_o),
    .Illegal_o   (Illegal_o),
    .Timeout_o   (Timeout_o),
    .State_o     (State_o),
    .Retired_o   (Retired_o)
  );

  // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCWrite,Illegal}
  logic [15:0] ctl;
  logic [4:0]  writes;
  assign ctl = {IorD_o, MemRead_o, MemWrite_o, IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o,
                ALUSrcA_o, ALUSrcB_o, ALUOp_o, PCSrc_o, PCWrite_o, Illegal_o};
  assign writes = {MemRead_o, MemWrite_o, IRWrite_o, RegWrite_o, PCWrite_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check state and control vector mid-cycle, then advance.
  task automatic cyc(input logic rdy, input logic z, input logic [3:0] st,
                     input logic [15:0] exp_ctl, input string tag);
    mem_ready_i = rdy;
    Zero_i      = z;
    #1;
    chk({tag, " state"}, {28'd0, State_o}, {28'd0, st});
    chk({tag, " ctl"}, {16'd0, ctl}, {16'd0, exp_ctl});
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i       = 1'b1;
    mem_ready_i = 1'b1;
    Zero_i      = 1'b0;
    Op_i        = 6'b000000;
    @(posedge clk_i); #1;
    chk("reset writes c1", {27'd0, writes}, 32'd0);
    @(posedge clk_i); #1;
    chk("reset writes c2", {27'd0, writes}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("reset state", {28'd0, State_o}, 32'd0);
    chk("reset retired", Retired_o, 32'd0);
    chk("reset timeout", {31'd0, Timeout_o}, 32'd0);

    // add
    Op_i = 6'b000000;
    cyc(1, 0, 4'd0, 16'h5052, "add fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "add decode");
    cyc(1, 0, 4'd6, 16'h0100, "add exec_r");
    cyc(1, 0, 4'd7, 16'h0A00, "add aluwb");
    chk("add end state", {28'd0, State_o}, 32'd0);
    chk("add retired", Retired_o, 32'd1);

    // lw with two wait cycles in MEMRD
    Op_i = 6'b100011;
    cyc(1, 0, 4'd0, 16'h5052, "lw fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "lw decode");
    cyc(1, 0, 4'd2, 16'h0190, "lw memadr");
    cyc(0, 0, 4'd3, 16'hC000, "lw memrd w1");
    cyc(0, 0, 4'd3, 16'hC000, "lw memrd w2");
    cyc(1, 0, 4'd3, 16'hC000, "lw memrd rdy");
    cyc(1, 0, 4'd4, 16'h0600, "lw memwb");
    chk("lw retired", Retired_o, 32'd2);

    // beq taken then not taken
    Op_i = 6'b000100;
    cyc(1, 0, 4'd0, 16'h5052, "beq1 fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "beq1 decode");
    cyc(1, 1, 4'd9, 16'h0136, "beq1 branch");
    chk("beq1 retired", Retired_o, 32'd3);
    cyc(1, 0, 4'd0, 16'h5052, "beq0 fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "beq0 decode");
    cyc(1, 0, 4'd9, 16'h0134, "beq0 branch");
    chk("beq0 retired", Retired_o, 32'd4);

    // illegal opcode
    Op_i = 6'b111111;
    cyc(1, 0, 4'd0, 16'h5052, "ill fetch");
    cyc(1, 0, 4'd1, 16'h00D1, "ill decode");
    chk("ill next state", {28'd0, State_o}, 32'd0);
    chk("ill retired", Retired_o, 32'd4);

    // j, with one fetch wait cycle
    Op_i = 6'b000010;
    cyc(0, 0, 4'd0, 16'h4050, "j fetch wait");
    cyc(1, 0, 4'd0, 16'h5052, "j fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "j decode");
    cyc(1, 0, 4'd10, 16'h000A, "j jump");
    chk("j retired", Retired_o, 32'd5);

    // ori then addi
    Op_i = 6'b001101;
    cyc(1, 0, 4'd0, 16'h5052, "ori fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "ori decode");
    cyc(1, 0, 4'd8, 16'h01A0, "ori exec_i");
    cyc(1, 0, 4'd7, 16'h0200, "ori aluwb");
    Op_i = 6'b001000;
    cyc(1, 0, 4'd0, 16'h5052, "addi fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "addi decode");
    cyc(1, 0, 4'd8, 16'h0190, "addi exec_i");
    cyc(1, 0, 4'd7, 16'h0200, "addi aluwb");
    chk("ori/addi retired", Retired_o, 32'd7);

    // sw with one wait cycle
    Op_i = 6'b101011;
    cyc(1, 0, 4'd0, 16'h5052, "sw fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "sw decode");
    cyc(1, 0, 4'd2, 16'h0190, "sw memadr");
    cyc(0, 0, 4'd5, 16'hA000, "sw memwr wait");
    cyc(1, 0, 4'd5, 16'hA000, "sw memwr rdy");
    chk("sw retired", Retired_o, 32'd8);

    // reset in ALUWB abandons the write
    Op_i = 6'b000000;
    cyc(1, 0, 4'd0, 16'h5052, "rst add fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "rst add decode");
    cyc(1, 0, 4'd6, 16'h0100, "rst add exec_r");
    rst_i = 1'b1;
    #1;
    chk("mid reset writes", {27'd0, writes}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("mid reset state", {28'd0, State_o}, 32'd0);
    chk("mid reset retired", Retired_o, 32'd0);

    // sw with memory never ready
    Op_i = 6'b101011;
    cyc(1, 0, 4'd0, 16'h5052, "to fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "to decode");
    cyc(1, 0, 4'd2, 16'h0190, "to memadr");
`ifdef MC_TIMEOUT_EN
    for (int i = 0; i < 16; i++) cyc(0, 0, 4'd5, 16'hA000, "to memwr");
    #1;
    chk("to state", {28'd0, State_o}, 32'd0);
    chk("to flag", {31'd0, Timeout_o}, 32'd1);
    chk("to retired", Retired_o, 32'd0);
    Op_i = 6'b000010;
    cyc(1, 0, 4'd0, 16'h5052, "post-to fetch");
    cyc(1, 0, 4'd1, 16'h00D0, "post-to decode");
    cyc(1, 0, 4'd10, 16'h000A, "post-to jump");
    chk("to sticky", {31'd0, Timeout_o}, 32'd1);
    chk("post-to retired", Retired_o, 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("to cleared", {31'd0, Timeout_o}, 32'd0);
`else
    for (int i = 0; i < 20; i++) cyc(0, 0, 4'd5, 16'hA000, "nowait memwr");
    chk("no timeout", {31'd0, Timeout_o}, 32'd0);
    cyc(1, 0, 4'd5, 16'hA000, "nowait memwr rdy");
    chk("nowait state", {28'd0, State_o}, 32'd0);
    chk("nowait retired", Retired_o, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle opcode decoder when the datapath shares one ALU and one memory port across cycles. Walks each instruction through fetch, decode, execute, memory and writeback states, handshaking with memory through a ready signal. Drives all datapath mux selects and write enables, and counts retired instructions.

## Interface
- WAIT_MAX, default 15: maximum cycles a memory state waits for `mem_ready_i` before abort; only used under `MC_TIMEOUT_EN`.
- clk_i  input  1  clock
- rst_i  input  1  synchronous reset, active-high
- Op_i  input  6  opcode of the instruction register, valid from DECODE on
- Zero_i  input  1  ALU zero flag
- mem_ready_i  input  1  memory completes the current read/write this cycle
- IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead_o  output  1  memory read request
- MemWrite_o  output  1  memory write request
- IRWrite_o  output  1  instruction register load
- RegDst_o  output  1  write register: 1 = rd, 0 = rt
- MemtoReg_o  output  1  write data: 1 = MDR, 0 = ALUOut
- RegWrite_o  output  1  register file write
- ALUSrcA_o  output  1  0 = PC, 1 = reg A
- ALUSrcB_o  output  2  00 = reg B, 01 = 4, 10 = ext imm, 11 = ext imm<<2
- ALUOp_o  output  2  00 = R-type (funct), 01 = ADD, 10 = OR, 11 = SUB
- PCSrc_o  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- PCWrite_o  output  1  PC load
- Illegal_o  output  1  one-cycle pulse on an unsupported opcode
- Timeout_o  output  1  sticky memory timeout flag
- State_o  output  4  current state code, for debug
- Retired_o  output  32  retired instruction count

## Operation
- Supported opcodes:
  - 000000 R-type
  - 001000 addi
  - 001101 ori
  - 100011 lw
  - 101011 sw
  - 000100 beq
  - 000010 j
- States and codes:
  - FETCH(0): IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=01, PCSrc=00.
    - IRWrite = PCWrite = mem_ready_i.
    - Go to DECODE when mem_ready_i is 1; otherwise hold.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=01 (precompute branch target). Next state by Op_i:
    - lw/sw → MEMADR
    - R-type → EXEC_R
    - addi/ori → EXEC_I
    - beq → BRANCH
    - j → JUMP
    - anything else → FETCH, with Illegal_o=1 this cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=01. lw → MEMRD, sw → MEMWR.
  - MEMRD(3): IorD=1, MemRead=1. On mem_ready_i → MEMWB; otherwise hold.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Retires. → FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. On mem_ready_i: retires, → FETCH; otherwise hold.
  - EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUOp=00. → ALUWB.
  - ALUWB(7): MemtoReg=0, RegWrite=1, RegDst = 1 for R-type, 0 for addi/ori. Retires. → FETCH.
  - EXEC_I(8): ALUSrcA=1, ALUSrcB=10, ALUOp = 01 for addi, 10 for ori. → ALUWB.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=11, PCSrc=01, PCWrite=Zero_i. Retires. → FETCH.
  - JUMP(10): PCSrc=10, PCWrite=1. Retires. → FETCH.
- Any signal not listed for a state is 0.
- Op_i is sampled only in DECODE. The datapath holds the IR stable until the next FETCH completes. In ALUWB, RegDst uses Op_i.
- Retired_o increments by 1 on the last cycle of each supported instruction and wraps 0xFFFFFFFF → 0. Illegal and aborted instructions do not count.
- State codes 11–15 are unreachable. If entered, next state is FETCH with all outputs 0.

## Timing
- Reset:
  - While rst_i=1, every write/request output (MemRead, MemWrite, IRWrite, RegWrite, PCWrite) is forced to 0.
  - At the clock edge: state=FETCH, Retired_o=0, Timeout_o=0, wait counter=0.
  - A reset asserted mid-instruction abandons it with no write in the reset cycle.
- Cycle counts with zero memory wait:
  - lw = 5
  - R-type, addi, ori, sw = 4
  - beq, j = 3
  - illegal = 2
- Each cycle mem_ready_i is low in FETCH, MEMRD or MEMWR adds one cycle. Request outputs stay asserted and unchanged while waiting.
- mem_ready_i outside FETCH, MEMRD and MEMWR is ignored.
- Outputs are a combinational decode of the state register, plus mem_ready_i in FETCH and Zero_i in BRANCH. No output is registered.

## Configuration
- `MC_TIMEOUT_EN` defined:
  - A wait counter of $clog2(WAIT_MAX+1) bits increments each cycle a memory state sees mem_ready_i=0, and clears on leaving the state.
  - When the counter equals WAIT_MAX and mem_ready_i is still 0: Timeout_o is set (sticky until reset), the next state is FETCH, and no retire occurs.
- `MC_TIMEOUT_EN` undefined: no counter, memory states wait indefinitely, Timeout_o tied 0.

## Test plan
- Reset: hold rst_i for 2 cycles with mem_ready_i=1. Required: all enables 0, then State_o=0, Retired_o=0, Timeout_o=0.
- add (Op=000000), ready always 1. Required:
  - State_o sequence 0,1,6,7,0.
  - RegWrite=1 and RegDst=1 in cycle 4 only.
  - Retired_o=1.
- lw with mem_ready_i low for 2 cycles in MEMRD. Required:
  - Sequence 0,1,2,3,3,3,4,0, with MemRead/IorD=1 held through MEMRD.
  - MemtoReg=1 and RegWrite=1 in MEMWB.
- beq (Op=000100) with Zero_i=1, then again with Zero_i=0. Required: PCWrite=1 with PCSrc=01 in BRANCH for the first, PCWrite=0 for the second. Both retire.
- Op=111111. Required: Illegal_o pulses in DECODE, next state FETCH, Retired_o unchanged.
- `MC_TIMEOUT_EN`, WAIT_MAX=15, sw with mem_ready_i held 0. Required: Timeout_o rises after 16 MEMWR cycles, state returns to FETCH, Retired_o unchanged, and Timeout_o stays 1 until rst_i.
